uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one byte-wide UART transmitter between NUM_REQ requesters.
//  Arbitration is round-robin at message granularity: a grant is held until the requester's last byte
//  (req_last) or MAX_MSG_LEN bytes, so messages never interleave on the line.
//  Drives the serializer's tx_data/tx_start, paces on tx_busy, and inserts an idle gap between messages.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  MAX_MSG_LEN  64   max bytes per grant; grant force-released at this count
//  GAP_CYCLES   16   clk cycles of line idle enforced after each message (>=1)
// PORTS
//  clk           in   1          system clock (27 MHz)
//  rst           in   1          synchronous, active-high reset
//  req_valid     in   NUM_REQ    requester i has a byte on req_data[8i+7:8i]
//  req_data      in   8*NUM_REQ  packed bytes, requester i at [8i+7:8i]
//  req_last      in   NUM_REQ    byte on req_data is final byte of message
//  req_ready     out  NUM_REQ    one-hot; byte of requester i accepted when valid&ready
//  tx_data       out  8          byte to serializer, stable from tx_start until tx_busy falls
//  tx_start      out  1          one-cycle pulse: serializer loads tx_data
//  tx_busy       in   1          serializer busy (start bit through stop bit)
//  grant_id      out  clog2(NUM_REQ) index of current owner
//  grant_active  out  1          a message is in progress (states SEND..WAIT_DONE)
//  msg_trunc     out  1          one-cycle pulse when grant released by MAX_MSG_LEN, not req_last
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0, tx_data=8'h00, tx_start=0, grant_id=0, grant_active=0, msg_trunc=0,
//   byte count=0, gap count=0; rr pointer last_grant=NUM_REQ-1 (requester 0 wins first). Reset mid-message
//   abandons it at once; serializer finishes its current byte on its own.
//  FSM: IDLE -> SEND -> WAIT_ACK -> WAIT_DONE -> (SEND | GAP) ; GAP -> IDLE.
//  IDLE: if any req_valid, grant = first valid index searching last_grant+1, +2, ... mod NUM_REQ;
//   register grant_id, last_grant=grant, byte count=0, go SEND. No valid: stay. Arbitration costs 1 cycle.
//  SEND: req_ready[grant_id]=1 (registered-state decode, others 0). On valid&ready: tx_data<=byte,
//   tx_start<=1 next cycle, latch end=req_last|(count==MAX_MSG_LEN-1), count+1, go WAIT_ACK.
//   Owner deasserting valid mid-message: grant held, SEND waits indefinitely (no re-arbitration).
//  WAIT_ACK: tx_start high exactly first cycle here; wait for tx_busy=1, then WAIT_DONE.
//  WAIT_DONE: wait tx_busy=0; then if end: GAP (msg_trunc pulses same cycle if end was by count
//   only), else SEND. If tx_busy is already high on entry to SEND's successor, no byte is lost:
//   tx_start only issued after tx_busy seen low.
//  GAP: count GAP_CYCLES cycles, grant_active=0, req_ready=0; then IDLE.
//  Latency: req_valid in IDLE -> req_ready after 1 clk; accept -> tx_start next clk.
//  Max one byte outstanding; req_ready never high while tx_busy-pacing states active.
//  Simultaneous valid from several requesters: only rr winner served; others wait (no drop).
//  req_last together with count reaching MAX_MSG_LEN: normal end, msg_trunc=0.
//  Pointer wraps NUM_REQ-1 -> 0. Byte count width clog2(MAX_MSG_LEN+1); never wraps.
// TESTING
//  1. Single req0 sends 3 bytes 41,42,43 (last on 43) with 10-bit-time busy model -> 3 tx_start pulses,
//     tx_data 41,42,43 in order, grant_id=0, then 16 idle cycles before any new grant.
//  2. req0..req3 all valid from reset, 1-byte messages -> grant order 0,1,2,3,0; no interleave.
//  3. req1 message of 70 bytes, req_last never set, MAX_MSG_LEN=64 -> release after byte 64,
//     msg_trunc 1-cycle pulse, req2 (waiting) granted next, req1 resumes on later round.
//  4. Owner drops req_valid for 500 cycles mid-message while req3 valid -> no grant change, tx idle,
//     resumes with owner's next byte.
//  5. rst asserted during WAIT_DONE of byte 2 -> next cycle all outputs at reset values, req0 wins first.
//  6. Serializer asserts tx_busy 3 cycles late after tx_start -> scheduler waits, no second start.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Requester/serializer bundle for uart_tx_scheduler.
// The slave modport is the scheduler; master is the requesters plus the serializer.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [GW-1:0]        grant_id;
    logic                 grant_active;
    logic                 msg_trunc;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, grant_active, msg_trunc
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, grant_active, msg_trunc
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Message-granular round-robin scheduler sharing one byte-wide UART transmitter
// between NUM_REQ requesters, with one byte outstanding and an idle gap after each message.
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_MSG_LEN = 64,
    parameter int GAP_CYCLES  = 16
) (
    input logic                clk,
    input logic                rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int          GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          CW        = $clog2(MAX_MSG_LEN + 1);
    localparam int          GAPW      = $clog2(GAP_CYCLES + 1);
    localparam int unsigned NUM_REQ_U = NUM_REQ;
    localparam logic [CW-1:0]      CNT_LAST = CW'(MAX_MSG_LEN - 1);
    localparam logic [GAPW-1:0]    GAP_LAST = GAPW'(GAP_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
    localparam logic [GW-1:0]      PTR_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      grant_q;
    logic [CW-1:0]      byte_cnt;
    logic [GAPW-1:0]    gap_cnt;
    logic               msg_end;
    logic               end_by_count;
    logic [NUM_REQ-1:0] ready_q;
    logic [7:0]         data_q;
    logic               start_q;
    logic               active_q;
    logic               trunc_q;

    logic               found;
    logic [GW-1:0]      winner;
    logic [GW-1:0]      cand;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;
    logic               accept;
    logic [NUM_REQ-1:0] grant_mask;
    logic               at_limit;

    // First valid requester after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned off = 1; off <= NUM_REQ_U; off++) begin
            cand = GW'((32'(last_grant) + off) % NUM_REQ_U);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign own_valid  = bus.req_valid[grant_q];
    assign own_last   = bus.req_last[grant_q];
    assign own_data   = bus.req_data[{grant_q, 3'b000} +: 8];
    assign accept     = (state == SEND) && own_valid && ready_q[grant_q];
    assign grant_mask = ONE << grant_q;
    assign at_limit   = (byte_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= PTR_INIT;
            grant_q      <= '0;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            msg_end      <= 1'b0;
            end_by_count <= 1'b0;
            ready_q      <= '0;
            data_q       <= '0;
            start_q      <= 1'b0;
            active_q     <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            trunc_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q    <= winner;
                        last_grant <= winner;
                        byte_cnt   <= '0;
                        active_q   <= 1'b1;
                        ready_q    <= bus.tx_busy ? '0 : (ONE << winner);
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        data_q       <= own_data;
                        start_q      <= 1'b1;
                        msg_end      <= own_last || at_limit;
                        end_by_count <= !own_last && at_limit;
                        byte_cnt     <= byte_cnt + 1'b1;
                        ready_q      <= '0;
                        state        <= WAIT_ACK;
                    end else begin
                        // A serializer still busy from before a reset holds off the handshake.
                        ready_q <= bus.tx_busy ? '0 : grant_mask;
                    end
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (msg_end) begin
                            state    <= GAP;
                            gap_cnt  <= '0;
                            active_q <= 1'b0;
                            trunc_q  <= end_by_count;
                        end else begin
                            ready_q <= grant_mask;
                            state   <= SEND;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.tx_data      = data_q;
    assign bus.tx_start     = start_q;
    assign bus.grant_id     = grant_q;
    assign bus.grant_active = active_q;
    assign bus.msg_trunc    = trunc_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues, a serializer busy model,
// a transmit log, and table-driven plus hand-written multi-cycle sequences.
module tb_uart_tx_scheduler;
    localparam int NR       = 4;
    localparam int MAXL     = 64;
    localparam int GAPC     = 16;
    localparam int BUSY_LEN = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ    (NR),
        .MAX_MSG_LEN(MAXL),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         phase;
        int         req;
        logic [7:0] data;
        bit         last;
        int         exp_gid;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        int         gid;
        logic [7:0] data;
    } ent_t;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    bit [8:0] rq [NR][$];
    ent_t     txlog[$];

    int busy_delay = 0;
    int delay_left = 0;
    int busy_left  = 0;
    bit pend       = 0;

    int         trunc_cnt = 0;
    int         trunc_at  = -1;
    bit         prev_trunc = 0;
    bit         prev_ga    = 0;
    bit         seen_fall  = 0;
    int         run        = 0;
    int         last_run   = -1;
    logic [7:0] held;
    bit         hold_chk   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic chk_ent(input string name, input int j, input int gid, input int data);
        int g, d;
        g = -1;
        d = -1;
        if (j < txlog.size()) begin
            g = txlog[j].gid;
            d = int'(txlog[j].data);
        end
        chk({name, "_gid"}, g, gid);
        chk({name, "_data"}, d, data);
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (txlog.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_reached"}, int'(txlog.size() >= n), 1);
    endtask

    task automatic begin_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        repeat (3) tick();
        txlog.delete();
    endtask

    task automatic end_reset();
        rst       = 1'b0;
        seen_fall = 1'b0;
        last_run  = -1;
        trunc_cnt = 0;
        trunc_at  = -1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, int'(bus.req_ready), 0);
        chk({name, "_txdata"}, int'(bus.tx_data), 0);
        chk({name, "_start"}, int'(bus.tx_start), 0);
        chk({name, "_gid"}, int'(bus.grant_id), 0);
        chk({name, "_active"}, int'(bus.grant_active), 0);
        chk({name, "_trunc"}, int'(bus.msg_trunc), 0);
    endtask

    // Requesters: present queue heads, pop after each accepting edge.
    initial begin
        bit              acc [NR];
        logic [NR-1:0]   v, l;
        logic [8*NR-1:0] d;
        bit [8:0]        h;
        for (int i = 0; i < NR; i++) acc[i] = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    h            = rq[i][0];
                    v[i]         = 1'b1;
                    l[i]         = h[8];
                    d[8*i +: 8]  = h[7:0];
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
            for (int i = 0; i < NR; i++) acc[i] = v[i] && bus.req_ready[i] && !rst;
        end
    end

    // Serializer: busy_delay cycles after tx_start, busy for BUSY_LEN cycles; ignores reset.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.tx_busy = 1'b0;
            end
            if (bus.tx_start && !pend && busy_left == 0) begin
                pend       = 1'b1;
                delay_left = busy_delay;
            end
            if (pend) begin
                if (delay_left == 0) begin
                    pend        = 1'b0;
                    busy_left   = BUSY_LEN;
                    bus.tx_busy = 1'b1;
                end else begin
                    delay_left--;
                end
            end
        end
    end

    // Monitor: transmit log, pulse/one-hot/pacing invariants, grant-idle run length.
    initial begin
        bit model_act;
        forever begin
            @(negedge clk);
            model_act = pend || (busy_left > 0);
            if (rst) hold_chk = 1'b0;
            if (bus.tx_start) begin
                if (model_act) viol++;
                txlog.push_back('{gid: int'(bus.grant_id), data: bus.tx_data});
                held     = bus.tx_data;
                hold_chk = 1'b1;
            end else if (hold_chk && model_act && bus.tx_data != held) begin
                viol++;
            end
            if (!model_act && !bus.tx_start) hold_chk = 1'b0;
            if ($countones(bus.req_ready) > 1) viol++;
            if (bus.req_ready != '0 && bus.tx_busy) viol++;
            if (bus.msg_trunc) begin
                if (prev_trunc) viol++;
                trunc_cnt++;
                trunc_at = txlog.size();
            end
            prev_trunc = bus.msg_trunc;
            if (prev_ga && !bus.grant_active) begin
                seen_fall = 1'b1;
                run       = 0;
            end
            if (!bus.grant_active) run++;
            else if (!prev_ga && seen_fall) last_run = run;
            prev_ga = bus.grant_active;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   j, n, bad;

        vecs[0] = '{1, 0, 8'h41, 1'b0, 0, 8'h41};
        vecs[1] = '{1, 0, 8'h42, 1'b0, 0, 8'h42};
        vecs[2] = '{1, 0, 8'h43, 1'b1, 0, 8'h43};
        vecs[3] = '{1, 0, 8'h44, 1'b1, 0, 8'h44};
        vecs[4] = '{2, 0, 8'hA0, 1'b1, 0, 8'hA0};
        vecs[5] = '{2, 1, 8'hB1, 1'b1, 1, 8'hB1};
        vecs[6] = '{2, 2, 8'hC2, 1'b1, 2, 8'hC2};
        vecs[7] = '{2, 3, 8'hD3, 1'b1, 3, 8'hD3};
        vecs[8] = '{2, 0, 8'hE0, 1'b1, 0, 8'hE0};

        begin_reset();
        chk_reset_outputs("reset");

        // Tests 1 and 2: table rows are pushed into queues, then the log must match in row order.
        for (int p = 1; p <= 2; p++) begin
            begin_reset();
            n = 0;
            for (int k = 0; k < 9; k++) begin
                if (vecs[k].phase == p) begin
                    rq[vecs[k].req].push_back({vecs[k].last, vecs[k].data});
                    n++;
                end
            end
            end_reset();
            wait_log($sformatf("t%0d", p), n, 3000);
            repeat (40) tick();
            chk($sformatf("t%0d_count", p), txlog.size(), n);
            j = 0;
            for (int k = 0; k < 9; k++) begin
                if (vecs[k].phase == p) begin
                    chk_ent($sformatf("t%0d_e%0d", p, j), j, vecs[k].exp_gid, int'(vecs[k].exp_data));
                    j++;
                end
            end
            // GAP_CYCLES in GAP plus the one arbitration cycle in IDLE.
            if (p == 1) chk("t1_gap_low_cycles", last_run, GAPC + 1);
            chk($sformatf("t%0d_invariants", p), viol, 0);
        end

        // Test 3: 70-byte message without req_last, req2 waiting.
        begin_reset();
        for (int b = 0; b < 70; b++) rq[1].push_back({1'b0, 8'(b)});
        rq[2].push_back({1'b1, 8'hC2});
        end_reset();
        wait_log("t3", 71, 6000);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (k >= txlog.size() || txlog[k].gid != 1 || txlog[k].data != 8'(k)) bad++;
        end
        chk("t3_first64", bad, 0);
        chk_ent("t3_req2", 64, 2, 8'hC2);
        bad = 0;
        for (int k = 65; k < 71; k++) begin
            if (k >= txlog.size() || txlog[k].gid != 1 || txlog[k].data != 8'(k - 1)) bad++;
        end
        chk("t3_resume", bad, 0);
        repeat (20) tick();
        chk("t3_trunc_count", trunc_cnt, 1);
        chk("t3_trunc_after_byte", trunc_at, 64);
        chk("t3_owner_waiting_gid", int'(bus.grant_id), 1);
        chk("t3_owner_waiting_active", int'(bus.grant_active), 1);
        chk("t3_invariants", viol, 0);

        // Test 4: owner goes silent for 500 cycles while req3 is valid.
        begin_reset();
        rq[0].push_back({1'b0, 8'h10});
        rq[0].push_back({1'b0, 8'h11});
        rq[3].push_back({1'b1, 8'h33});
        end_reset();
        wait_log("t4_pre", 2, 1000);
        bad = 0;
        repeat (500) begin
            tick();
            if (bus.grant_id != 0 || !bus.grant_active || txlog.size() != 2 || bus.tx_start) bad++;
        end
        chk("t4_hold", bad, 0);
        rq[0].push_back({1'b1, 8'h12});
        wait_log("t4_post", 4, 1000);
        chk_ent("t4_e0", 0, 0, 8'h10);
        chk_ent("t4_e1", 1, 0, 8'h11);
        chk_ent("t4_e2", 2, 0, 8'h12);
        chk_ent("t4_e3", 3, 3, 8'h33);
        chk("t4_invariants", viol, 0);

        // Test 5: reset while the second byte is in WAIT_DONE.
        begin_reset();
        rq[0].push_back({1'b0, 8'h50});
        rq[0].push_back({1'b0, 8'h51});
        rq[0].push_back({1'b1, 8'h52});
        end_reset();
        wait_log("t5_pre", 2, 1000);
        repeat (3) tick();
        chk("t5_busy_at_reset", int'(bus.tx_busy), 1);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        tick();
        chk_reset_outputs("t5_reset");
        txlog.delete();
        rq[1].push_back({1'b1, 8'hB1});
        rq[0].push_back({1'b1, 8'hB0});
        tick();
        end_reset();
        wait_log("t5_post", 2, 1000);
        chk_ent("t5_e0", 0, 0, 8'hB0);
        chk_ent("t5_e1", 1, 1, 8'hB1);
        chk("t5_invariants", viol, 0);

        // Test 6: serializer raises tx_busy 3 cycles after tx_start.
        busy_delay = 3;
        begin_reset();
        rq[2].push_back({1'b0, 8'h61});
        rq[2].push_back({1'b1, 8'h62});
        end_reset();
        wait_log("t6", 2, 1000);
        repeat (40) tick();
        chk("t6_count", txlog.size(), 2);
        chk_ent("t6_e0", 0, 2, 8'h61);
        chk_ent("t6_e1", 1, 2, 8'h62);
        chk("t6_invariants", viol, 0);
        busy_delay = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
